// File: rtl/mult_div_controller_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding, op codes,
// and the default iteration counts that the CPU control unit also uses for stall accounting.
package mult_div_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2,
    S_EXC   = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MULT_CYCLES_DEF = 33;
  localparam int DIV_CYCLES_DEF  = 33;
  localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/mult_div_controller_if.sv
// Handshake bundle between the CPU control unit / mult-div datapath (master side)
// and the mult/div sequencer (slave side).
interface mult_div_controller_if;
  logic start;
  logic op;
  logic divide_by_zero;
  logic md_control;
  logic md_reset;
  logic operand_hold;
  logic busy;
  logic hilo_write;
  logic done;
  logic div0_exception;

  modport master (
    output start, op, divide_by_zero,
    input  md_control, md_reset, operand_hold, busy, hilo_write, done, div0_exception
  );

  modport slave (
    input  start, op, divide_by_zero,
    output md_control, md_reset, operand_hold, busy, hilo_write, done, div0_exception
  );
endinterface

// File: rtl/mult_div_controller.sv
// Sequencer for the iterative 32-bit mult/div unit: accepts a start, runs the unit for a fixed
// number of iterations, then pulses Hi/Lo write + done, or raises a divide-by-zero exception.
//
//   state   | meaning
//   S_IDLE  | waiting for start; unit held in reset so it keeps loading operands
//   S_RUN   | unit iterating; cnt counts edges, operands frozen
//   S_WRITE | result valid; one-cycle hilo_write + done
//   S_EXC   | divide by zero seen; one-cycle div0_exception, Hi/Lo untouched
module mult_div_controller
  import mult_div_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  Reset,
  mult_div_controller_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_last;
  logic             op_q;
  logic             op_nxt;

  assign cnt_last = (op_q == OP_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= OP_MULT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          op_nxt    = bus.op;
        end
      end
      S_RUN: begin
        // Stop counting on the exit edge so cnt never runs past the terminal value.
        if (op_q == OP_DIV && bus.divide_by_zero) begin
          state_nxt = S_EXC;
        end else if (cnt == cnt_last) begin
          state_nxt = S_WRITE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_EXC:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // md_reset stays low in WRITE so the unit keeps Hi/Lo stable while they are captured.
  assign bus.md_reset       = Reset | (state == S_IDLE);
  assign bus.md_control     = op_q;
  assign bus.busy           = (state != S_IDLE);
  assign bus.operand_hold   = (state == S_RUN);
  assign bus.hilo_write     = (state == S_WRITE);
  assign bus.done           = (state == S_WRITE);
  assign bus.div0_exception = (state == S_EXC);

endmodule

// File: tb/tb_mult_div_controller.sv
// Scoreboard bench for mult_div_controller paired with a behavioural 33-cycle mult/div unit.
module tb_mult_div_controller;
  import mult_div_controller_pkg::*;

  logic clock = 1'b0;
  logic Reset;
  mult_div_controller_if bus ();

  mult_div_controller dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural mult/div unit: loads operands while in local reset, result valid after 33 run edges.
  logic [31:0] opa = '0, opb = '0;
  logic [31:0] a_q = '0, b_q = '0;
  logic [31:0] unit_hi, unit_lo;
  logic [31:0] hi_arch = '0, lo_arch = '0;
  int run_edges = 0;
  logic signed [31:0] sa_q, sb_q, quo_s, rem_s;
  logic signed [63:0] ea, eb, prod_s;

  always @(posedge clock) begin
    if (bus.md_reset) begin
      a_q <= opa;
      b_q <= opb;
      run_edges <= 0;
    end else begin
      run_edges <= run_edges + 1;
    end
    if (bus.hilo_write) begin
      hi_arch <= unit_hi;
      lo_arch <= unit_lo;
    end
  end

  always_comb begin
    sa_q = a_q;
    sb_q = b_q;
    ea = sa_q;
    eb = sb_q;
    prod_s = ea * eb;
    quo_s = '0;
    rem_s = '0;
    if (sb_q != 0) begin
      quo_s = sa_q / sb_q;
      rem_s = sa_q % sb_q;
    end
    if (run_edges < 33) begin
      unit_hi = 32'hDEAD_0000;
      unit_lo = 32'h0000_BEEF;
    end else if (bus.md_control) begin
      unit_hi = rem_s;
      unit_lo = quo_s;
    end else begin
      unit_hi = prod_s[63:32];
      unit_lo = prod_s[31:0];
    end
  end

  assign bus.divide_by_zero = bus.md_control && !bus.md_reset && (b_q == 32'd0);

  typedef struct {
    bit          exc;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   busy_from  = 1;
  int   busy_until = 0;
  int   hold_until = 0;
  logic op_exp     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle handshake expectations plus scoreboard pops on done/exception pulses.
  always @(negedge clock) begin
    if (started) begin
      exp_t e;
      bit   bexp;
      bexp = (cyc >= busy_from) && (cyc <= busy_until);
      chk("busy", 32'(bus.busy), 32'(bexp));
      chk("md_reset", 32'(bus.md_reset), 32'(Reset || !bexp));
      chk("operand_hold", 32'(bus.operand_hold), 32'(bexp && (cyc <= hold_until)));
      if (bexp) chk("md_control", 32'(bus.md_control), 32'(op_exp));
      chk("hilo_write_vs_done", 32'(bus.hilo_write), 32'(bus.done));
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        chk("missed_pulse", 32'(cyc), 32'(sbq[0].due));
        void'(sbq.pop_front());
      end
      if (bus.done || bus.div0_exception) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", 32'(bus.done || bus.div0_exception), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(e.due));
          chk("div0_exception", 32'(bus.div0_exception), 32'(e.exc));
          chk("done", 32'(bus.done), 32'(!e.exc));
          if (!e.exc) begin
            chk("hi", unit_hi, e.hi);
            chk("lo", unit_lo, e.lo);
          end
        end
      end
    end
  end

  // Reference: signed 64-bit product for MULT, truncating quotient/remainder for DIV.
  task automatic issue(input logic opv, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    int     sa, sb;
    longint p;
    sa = a;
    sb = b;
    e.exc = opv && (b == 32'd0);
    e.hi = '0;
    e.lo = '0;
    if (!opv) begin
      p = longint'(sa) * longint'(sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (!e.exc) begin
      e.hi = sa % sb;
      e.lo = sa / sb;
    end
    e.due = cyc + (e.exc ? 2 : 34);
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.op = opv;
    opa = a;
    opb = b;
    busy_from = cyc + 1;
    busy_until = e.due;
    hold_until = e.due - 1;
    op_exp = opv;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && cyc <= busy_until; k++) begin
      @(posedge clock); #1;
    end
    if (cyc <= busy_until) chk("wait_idle_timeout", 32'(cyc), 32'(busy_until + 1));
  endtask

  initial begin
    logic [31:0] hi_save, lo_save;
    logic        rop;
    logic [31:0] ra, rb;
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 1'b0;
    @(posedge clock); #1;
    started = 1'b1;
    @(posedge clock); #1;
    chk("rst_md_control", 32'(bus.md_control), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_div0", 32'(bus.div0_exception), 32'd0);
    @(posedge clock); #1;
    Reset = 1'b0;
    @(posedge clock); #1;

    issue(1'b0, 32'd7, -32'sd3);
    wait_idle();
    chk("mult_hi_arch", hi_arch, 32'hFFFF_FFFF);
    chk("mult_lo_arch", lo_arch, 32'hFFFF_FFEB);

    issue(1'b1, 32'd100, 32'd7);
    wait_idle();
    chk("div_hi_arch", hi_arch, 32'd2);
    chk("div_lo_arch", lo_arch, 32'd14);

    hi_save = hi_arch;
    lo_save = lo_arch;
    issue(1'b1, 32'd55, 32'd0);
    wait_idle();
    chk("div0_hi_kept", hi_arch, hi_save);
    chk("div0_lo_kept", lo_arch, lo_save);

    // Reset in cycle 10 of a MULT aborts it silently.
    issue(1'b0, 32'd123, 32'd456);
    repeat (9) begin @(posedge clock); #1; end
    Reset = 1'b1;
    sbq.delete();
    busy_until = cyc;
    hold_until = cyc;
    @(posedge clock); #1;
    Reset = 1'b0;
    chk("abort_hi_kept", hi_arch, hi_save);
    issue(1'b0, 32'd5, 32'd6);
    wait_idle();
    chk("after_abort_lo", lo_arch, 32'd30);

    // start and op wiggled during RUN must be ignored.
    issue(1'b0, -32'sd9, 32'd11);
    for (int k = 0; k < 6; k++) begin
      bus.start = (k % 2 == 0);
      bus.op = ~bus.op;
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    bus.op = 1'b0;
    wait_idle();
    chk("ignore_start_lo", lo_arch, 32'hFFFF_FF9D);
    chk("ignore_start_hi", hi_arch, 32'hFFFF_FFFF);

    // Back-to-back: second start in the IDLE cycle right after done.
    issue(1'b1, -32'sd50, 32'd3);
    wait_idle();
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_idle();
    chk("b2b_hi_arch", hi_arch, 32'd1);
    chk("b2b_lo_arch", lo_arch, 32'd0);

    // Reset and start together: start dropped.
    bus.start = 1'b1;
    Reset = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    Reset = 1'b0;
    @(posedge clock); #1;

    for (int n = 0; n < 30; n++) begin
      rop = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (n % 3 == 0) rb = 32'($urandom_range(1, 20));
      if (rop && ra == 32'h8000_0000) ra = 32'd1;
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      issue(rop, ra, rb);
      wait_idle();
    end

    for (int k = 0; k < 50 && sbq.size() > 0; k++) begin
      @(posedge clock); #1;
    end
    if (sbq.size() > 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
